alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Operand-issue and result-capture stage wrapped around the 8-bit combinational ALU.
//  Buffers incoming {A,B,sel} requests in a small FIFO and presents the head entry to the ALU.
//  Registers ALU_Out/CarryOut and hands the result downstream over a valid/ready interface.
//  Decouples producer and consumer timing. Throughput 1 op/cycle when out_ready is held high.
// PARAMETERS
//  DATA_W  8  operand/result width; must match the ALU.
//  SEL_W   4  opcode width (ALU_Sel).
//  DEPTH   4  request FIFO entries; must be a power of 2 and at least 2.
// PORTS
//  clk        in   1       single clock; all logic is posedge.
//  rst        in   1       synchronous, active-high reset.
//  in_valid   in   1       request valid.
//  in_ready   out  1       FIFO not full; a push happens when in_valid && in_ready.
//  in_a       in   DATA_W  operand A.
//  in_b       in   DATA_W  operand B.
//  in_sel     in   SEL_W   opcode.
//  alu_a      out  DATA_W  to ALU A; head entry, or 0 when the FIFO is empty.
//  alu_b      out  DATA_W  to ALU B; head entry, or 0 when the FIFO is empty.
//  alu_sel    out  SEL_W   to ALU_Sel; head entry, or 0 when the FIFO is empty.
//  alu_out    in   DATA_W  from ALU_Out; combinational function of alu_a/alu_b/alu_sel.
//  alu_carry  in   1       from CarryOut.
//  out_valid  out  1       result register holds an unconsumed result.
//  out_ready  in   1       consumer accepts; a pop happens when out_valid && out_ready.
//  out_result out  DATA_W  registered alu_out.
//  out_carry  out  1       registered alu_carry.
//  out_sel    out  SEL_W   opcode that produced out_result (tag).
//  count      out  $clog2(DEPTH)+1  current FIFO occupancy.
// BEHAVIOUR
//  Reset: FIFO emptied, count=0, out_valid=0, out_result=0, out_carry=0, out_sel=0, state=IDLE.
//    in_ready=1 in the first cycle after reset.
//  Reset mid-operation: all queued requests and the held result are discarded. There is no drain.
//  in_ready = (count != DEPTH). It is registered-state-derived, with no combinational path from out_ready.
//  Capture condition cap = (count != 0) && (!out_valid || out_ready).
//    On cap: out_result <= alu_out, out_carry <= alu_carry, out_sel <= head sel.
//    On cap: out_valid <= 1 and the FIFO head is popped.
//    Else if out_valid && out_ready: out_valid <= 0.
//  Push and capture in the same cycle: count unchanged, both pointers advance.
//    Pointers wrap modulo DEPTH.
//  Push when full is impossible because in_ready=0. A push while full is ignored with no state change.
//  Latency: request accepted at edge N, with the FIFO previously empty.
//    It is head and on the ALU during cycle N..N+1. out_valid rises at edge N+1.
//  A request never bypasses the FIFO, so minimum latency is 1 cycle in and 1 cycle out.
//  Outputs out_result/out_carry/out_sel are held stable while out_valid && !out_ready.
//  Arithmetic is performed entirely by the ALU. This block never modifies the data.
//    All 2^SEL_W opcodes are forwarded unchanged.
//  FSM, 2-bit, reported for debug/coverage:
//    IDLE : count==0 && !out_valid.
//    RUN  : out_valid==0 or out_ready==1, with count>0 or out_valid.
//    STALL: out_valid && !out_ready.
//  FSM transitions follow from count and out_valid each cycle.
//    IDLE->RUN on push.
//    RUN->STALL when out_ready drops while out_valid.
//    STALL->RUN on out_ready.
//    RUN->IDLE when the last result is taken and the FIFO is empty.
// STRUCTURE
//  alu_pkg: DATA_W, SEL_W defaults; opcode constants ALU_ADD=0, ALU_SUB=1, ALU_MUL=2.
//  alu_pkg also holds the state enum {IDLE, RUN, STALL}.
//  Sub-module alu_op_fifo holds the synchronous FIFO of {a,b,sel}.
//    Ports: push/pop/full/empty/count/head.
//  The top level holds the result register, cap logic and FSM.
//  The ALU is instantiated beside this block, not inside it.
// TESTING
//  Bench instantiates alu_issue_stage + alu.
//  1 Single op: in A=8'h0F, B=8'h01, sel=0, out_ready=1.
//    -> out_valid 1 cycle later, out_result=8'h10, out_carry=0, out_sel=0.
//  2 Carry/wrap: A=8'hFF, B=8'h01, sel=0 -> out_result=8'h00, out_carry=1.
//    A=8'h03, B=8'h05, sel=1 -> out_result=8'hFE.
//  3 Backpressure: out_ready=0, push 5 ops (sel=2, A=3..7, B=2).
//    -> 1 result held + 4 queued, in_ready=0, count=4, state=STALL.
//    Release out_ready -> results 6,8,10,12,14 in order.
//  4 Streaming: in_valid=1 and out_ready=1 for 16 cycles with random A/B/sel.
//    -> one result per cycle; each result equals the ALU function of the matching request.
//  5 Reset mid-stream: assert rst with count=3 and out_valid=1.
//    -> next cycle out_valid=0, count=0, in_ready=1, all outputs 0, state=IDLE.
//  6 Simultaneous push+pop at count=DEPTH-1 -> count unchanged, pointers wrap, order preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   ALU_DATA_W / ALU_SEL_W : default operand and opcode widths of the companion ALU
//   ALU_ADD / ALU_SUB / ALU_MUL : opcode constants used by producers and benches
//   state_t  : debug state of the issue stage (IDLE, RUN, STALL)
//   state_of : classifies the stage from queued work, result-valid and consumer-ready
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_SEL_W  = 4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    function automatic state_t state_of(input logic queued, input logic valid,
                                        input logic ready);
        if (!queued && !valid) begin
            return IDLE;
        end else if (valid && !ready) begin
            return STALL;
        end else begin
            return RUN;
        end
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous request FIFO holding {a, b, sel} operand entries.
//   clk, rst         : clock and synchronous active-high reset (control state only)
//   push, wr_a/b/sel : enqueue request; ignored while full
//   pop              : dequeue head; ignored while empty
//   full, empty      : occupancy flags derived from registered count
//   count            : current occupancy, 0..DEPTH
//   head_a/b/sel     : oldest entry (undefined contents while empty)
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_a,
    input  logic [DATA_W-1:0]        wr_b,
    input  logic [SEL_W-1:0]         wr_sel,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head_a,
    output logic [DATA_W-1:0]        head_b,
    output logic [SEL_W-1:0]         head_sel
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_a   [DEPTH];
    logic [DATA_W-1:0] mem_b   [DEPTH];
    logic [SEL_W-1:0]  mem_sel [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointers are PTR_W bits wide, so DEPTH being a power of two makes them wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count and the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_a[wr_ptr]   <= wr_a;
            mem_b[wr_ptr]   <= wr_b;
            mem_sel[wr_ptr] <= wr_sel;
        end
    end

    always_comb begin
        head_a   = mem_a[rd_ptr];
        head_b   = mem_b[rd_ptr];
        head_sel = mem_sel[rd_ptr];
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue and result-capture stage around an external combinational ALU.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready, in_a/b/sel : request handshake and payload into the FIFO
//   alu_a/b/sel                : FIFO head driven to the ALU (zero while empty)
//   alu_out, alu_carry         : combinational ALU response
//   out_valid/out_ready        : result handshake towards the consumer
//   out_result/carry/sel       : registered ALU result and the opcode that produced it
//   count                      : FIFO occupancy
//   state                      : IDLE / RUN / STALL debug state
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [SEL_W-1:0]         alu_sel,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic                     alu_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic                     out_carry,
    output logic [SEL_W-1:0]         out_sel,
    output logic [$clog2(DEPTH):0]   count,
    output state_t                   state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              full;
    logic              empty;
    logic              cap;
    logic              push_ok;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [SEL_W-1:0]  head_sel;
    logic [CNT_W-1:0]  count_next;
    logic              valid_next;
    state_t            state_next;

    alu_op_fifo #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .pop      (cap),
        .wr_a     (in_a),
        .wr_b     (in_b),
        .wr_sel   (in_sel),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .head_a   (head_a),
        .head_b   (head_b),
        .head_sel (head_sel)
    );

    // in_ready depends only on registered occupancy, never on out_ready.
    always_comb begin
        in_ready = !full;
        push_ok  = in_valid && !full;
        cap      = !empty && (!out_valid || out_ready);
        alu_a    = empty ? '0 : head_a;
        alu_b    = empty ? '0 : head_b;
        alu_sel  = empty ? '0 : head_sel;
    end

    // Result register: loads the ALU response for the head entry, holds it under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_sel    <= '0;
        end else if (cap) begin
            out_valid  <= 1'b1;
            out_result <= alu_out;
            out_carry  <= alu_carry;
            out_sel    <= head_sel;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: classified from the occupancy and result-valid being loaded this edge.
    always_comb begin
        count_next = count;
        if (push_ok && !cap) begin
            count_next = count + 1'b1;
        end else if (cap && !push_ok) begin
            count_next = count - 1'b1;
        end
        valid_next = cap || (out_valid && !out_ready);
        state_next = state_of(count_next != '0, valid_next, out_ready);
    end

endmodule
